// File: rtl/icache_dm_pkg.sv
// Shared constants, FSM encoding and address-field helper for the direct-mapped I-cache.
package icache_dm_pkg;

   localparam logic RST_ENABLE   = 1'b0;
   localparam logic STOP         = 1'b1;
   localparam logic NO_STOP      = 1'b0;
   localparam logic BRANCH       = 1'b1;
   localparam int   EXC_ADEL_BIT = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REFILL,
      S_DONE
   } state_e;

   // Extract 'width' bits of an address starting at bit 'lsb'.
   function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
      logic [63:0] mask;
      mask = (64'd1 << width) - 64'd1;
      return (addr >> lsb) & mask;
   endfunction

endpackage

// File: rtl/icache_ram.sv
// Simple dual-port array: one synchronous write port, one asynchronous read port.
module icache_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache holding the fetch PC; refills whole lines word by word.
module icache_dm
   import icache_dm_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] new_pc,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_address_i,
   input  logic [ADDR_W-1:0] pc_pc,
   input  logic              invalidate_i,
   output logic [ADDR_W-1:0] icache_pc,
   output logic [DATA_W-1:0] inst_o,
   output logic              inst_valid_o,
   output logic              stallreq_o,
   output logic [31:0]       excepttype_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam int WORD_W = $clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TAG_W  = ADDR_W - 2 - WORD_W - IDX_W;

   state_e                  state_q, state_d;
   logic [ADDR_W-1:0]       pc_q, pc_d;
   logic                    ce_q;
   logic [NUM_LINES-1:0]    valid_q, valid_d;
   logic [WORD_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]        ridx_q, ridx_d;
   logic [TAG_W-1:0]        rtag_q, rtag_d;

   logic [WORD_W-1:0]       pc_word;
   logic [IDX_W-1:0]        pc_idx;
   logic [TAG_W-1:0]        pc_tag;
   logic [TAG_W-1:0]        tag_rd;
   logic [DATA_W-1:0]       data_rd;
   logic                    misaligned, lookup, hit, miss, beat, last, hold;
   logic                    unused_stall;

   assign unused_stall = ^{stall[5:3], stall[0]};

   assign pc_word = WORD_W'(addr_field(64'(pc_q), 2, WORD_W));
   assign pc_idx  = IDX_W'(addr_field(64'(pc_q), 2 + WORD_W, IDX_W));
   assign pc_tag  = TAG_W'(addr_field(64'(pc_q), 2 + WORD_W + IDX_W, TAG_W));

   icache_ram #(.WIDTH(DATA_W), .DEPTH(NUM_LINES * LINE_WORDS)) u_data (
      .clk_i   (clk),
      .we_i    (beat),
      .waddr_i ({ridx_q, cnt_q}),
      .wdata_i (mem_rdata_i),
      .raddr_i ({pc_idx, pc_word}),
      .rdata_o (data_rd)
   );

   icache_ram #(.WIDTH(TAG_W), .DEPTH(NUM_LINES)) u_tag (
      .clk_i   (clk),
      .we_i    (last),
      .waddr_i (ridx_q),
      .wdata_i (rtag_q),
      .raddr_i (pc_idx),
      .rdata_o (tag_rd)
   );

   // ce_q keeps the first post-reset cycle from looking up the reset PC.
   assign misaligned = (pc_q[1:0] != 2'b00);
   assign lookup     = ce_q && (state_q == S_IDLE);
   assign hit        = lookup && !misaligned && valid_q[pc_idx] && (tag_rd == pc_tag);
   assign miss       = lookup && !misaligned && !hit;
   assign beat       = (state_q == S_REFILL) && mem_ack_i;
   assign last       = beat && (cnt_q == WORD_W'(LINE_WORDS - 1));
   assign hold       = (state_q != S_IDLE) || miss;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ridx_d  = ridx_q;
      rtag_d  = rtag_q;
      unique case (state_q)
         S_IDLE: begin
            if (miss) begin
               state_d = S_REFILL;
               ridx_d  = pc_idx;
               rtag_d  = pc_tag;
               cnt_d   = '0;
            end
         end
         S_REFILL: begin
            if (beat) cnt_d = cnt_q + WORD_W'(1);
            if (last) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // A redirect during a fill is latched at once; the fill line address lives in ridx_q/rtag_q.
   always_comb begin
      pc_d = pc_q;
      if (flush) begin
         pc_d = new_pc;
      end else if (stall[1] == STOP && stall[2] == NO_STOP) begin
         pc_d = '0;
      end else if (stall[1] == NO_STOP) begin
         if (branch_flag_i == BRANCH) pc_d = branch_target_address_i;
         else if (!hold)              pc_d = pc_pc;
      end
   end

   // Invalidate clears first so a line finishing in the same cycle stays valid.
   always_comb begin
      valid_d = invalidate_i ? '0 : valid_q;
      if (last) valid_d[ridx_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ce_q    <= 1'b0;
         valid_q <= '0;
         cnt_q   <= '0;
         ridx_q  <= '0;
         rtag_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ce_q    <= 1'b1;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         ridx_q  <= ridx_d;
         rtag_q  <= rtag_d;
      end
   end

   always_comb begin
      excepttype_o               = '0;
      excepttype_o[EXC_ADEL_BIT] = lookup && misaligned;
   end

   assign icache_pc    = pc_q;
   assign inst_o       = hit ? data_rd : '0;
   assign inst_valid_o = lookup && (misaligned || hit);
   assign stallreq_o   = miss || (state_q == S_REFILL);
   assign mem_req_o    = (state_q == S_REFILL);
   assign mem_addr_o   = {rtag_q, ridx_q, cnt_q, 2'b00};

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
Parametrised direct-mapped instruction cache that replaces the plain IF-stage PC latch. It holds the fetch PC, looks up tag/data arrays, and refills a full line from memory over a valid/ack word interface. It raises a pipeline stall request on a miss and flags misaligned fetch (AdEL) in excepttype_o.
Sits between the PC stage and the IF/ID register. It honours the stall vector, flush and branch redirect.

Parameters:
ADDR_W, 32, fetch address width
DATA_W, 32, instruction word width
LINE_WORDS, 4, words per line (power of 2, >=2)
NUM_LINES, 64, number of lines (power of 2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
stall  in  6  pipeline stall vector; bit1 = IF, bit2 = ID
flush  in  1  exception flush
new_pc  in  ADDR_W  flush target
branch_flag_i  in  1  branch taken
branch_target_address_i  in  ADDR_W  branch target
pc_pc  in  ADDR_W  sequential next PC
invalidate_i  in  1  clear all valid bits (fence.i/cache op)
icache_pc  out  ADDR_W  registered fetch PC
inst_o  out  DATA_W  fetched instruction
inst_valid_o  out  1  inst_o usable this cycle
stallreq_o  out  1  miss/refill in progress, stall pipeline
excepttype_o  out  32  bit16 = fetch AdEL, other bits 0
mem_req_o  out  1  word read request
mem_addr_o  out  ADDR_W  word address of request
mem_ack_i  in  1  memory returned word
mem_rdata_i  in  DATA_W  returned word

Behaviour:
- Address split: offset[1:0] | word index log2(LINE_WORDS) | line index log2(NUM_LINES) | tag (remainder).
- Reset (rst=0, async): icache_pc=0; all valid=0; FSM=IDLE; mem_req_o=0; stallreq_o=0; inst_valid_o=0; word counter=0. Data/tag arrays are not reset.
- PC update priority per edge: flush -> new_pc; else stall[1]=1 & stall[2]=0 -> 0 (bubble); else stall[1]=0 & no refill -> branch target if branch_flag_i else pc_pc; otherwise hold.
- Misaligned (icache_pc[1:0]!=0): excepttype_o[16]=1, inst_valid_o=1, inst_o=0. No lookup, no refill, stallreq_o=0.
- Hit (IDLE, aligned, valid[idx] & tag match): combinational inst_o/inst_valid_o=1 in the same cycle; zero-latency.
- FSM states:
  - IDLE: on aligned miss, go to REFILL. stallreq_o=1 starting that cycle.
  - REFILL: mem_addr_o = {tag, idx, cnt, 2'b00}. mem_req_o held high until mem_ack_i. On each ack, write data[idx][cnt] and increment cnt. On ack with cnt=LINE_WORDS-1, write tag, set valid, cnt=0, go to DONE.
  - DONE: stallreq_o=0; return to IDLE. The lookup now hits. Miss penalty = LINE_WORDS acks + 2 cycles.
- Critical-word-first is not supported; fill always starts at word 0.
- Flush or branch redirect during REFILL: the line fill completes (memory beats are never aborted). The redirect PC is latched into icache_pc immediately. stallreq_o stays high until DONE, then lookup proceeds on the new PC.
- invalidate_i: all valid bits cleared next edge. If asserted during REFILL, the in-flight line is still marked valid on completion (invalidate precedes the fill).
- During REFILL, inst_valid_o=0.
- Simultaneous hit and invalidate_i: the current cycle still hits; the next cycle misses.

Decomposition:
- Shared package/defines.v: RstEnable polarity macro, Stop/NoStop, Branch, AdEL bit position (16), and a function for address-field extraction.
- One sub-module icache_ram: parametrised simple dual-port array (1 write, 1 async read) used for data and tag.
- The valid bitvector stays in the top module for single-cycle invalidate.

Test Plan:
1. Reset then pc_pc=0x100, memory returns 0xA0+word. Required: miss, then four reqs to 0x100/104/108/10C. Stall deasserts after DONE, inst_o=0xA0. The following fetch of 0x104 hits the same cycle with inst_o=0xA1.
2. Misaligned branch to 0x202. Required: excepttype_o=0x00010000, inst_valid_o=1, mem_req_o stays 0.
3. Flush with new_pc=0x80 during the second refill beat. Required: remaining beats complete, icache_pc=0x80 immediately, then 0x80 looks up (miss, new refill).
4. Conflict: fill 0x100, then fetch 0x100+LINE_WORDS*4*NUM_LINES (same index, different tag). Required: miss, line replaced, re-fetch of 0x100 misses again.
5. invalidate_i after filling 0x100. Required: the next fetch of 0x100 misses and refills.
6. rst driven low mid-REFILL. Required: mem_req_o=0, stallreq_o=0 and icache_pc=0 asynchronously. After release, 0x100 misses (valid cleared).
